scarv_cop_cprs_wrarb: RTL and testbench

Write-port arbiter and sequencer for the COP general-purpose register file, which has a single byte-enabled write port.
- Shares that port between NREQ result producers (e.g. ALU, memory unit, random unit) using round-robin arbitration and valid/ready handshakes.
- Sequences 64-bit "pair" results into two consecutive registers over two cycles.
- Drives crd_wen/crd_addr/crd_wdata from registers and generates the register file clock request.

---
 rtl/scarv_cop_pkg.sv | 11 +
 rtl/scarv_cop_rr_arb.sv | 32 +++
 rtl/scarv_cop_cprs_wrarb.sv | 126 ++++++++++++
 tb/tb_scarv_cop_cprs_wrarb.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scarv_cop_pkg.sv
// Shared constants for the COP register file write path.
package scarv_cop_pkg;

  localparam int CPRS_NUM = 16;
  localparam int CPRS_AW  = 4;
  localparam int XLEN     = 32;

  localparam logic S_IDLE = 1'b0;
  localparam logic S_HI   = 1'b1;

endpackage

// File: rtl/scarv_cop_rr_arb.sv
// Round-robin grant: first set request after ptr, wrapping modulo N.
module scarv_cop_rr_arb
  import scarv_cop_pkg::*;
#(
  parameter  int N  = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] gidx
);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = ptr;
    for (int i = 0; i < N; i++) begin
      idx = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = idx;
      end
    end
  end

endmodule

// File: rtl/scarv_cop_cprs_wrarb.sv
// Arbitrates the single register file write port between requesters
// and splits pair writes into two consecutive register writes.
module scarv_cop_cprs_wrarb
  import scarv_cop_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic                    g_clk,
  input  logic                    g_reset,
  output logic                    g_clk_req,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0]         req_pair,
  input  logic [NREQ*CPRS_AW-1:0] req_addr,
  input  logic [NREQ*4-1:0]       req_wen,
  input  logic [NREQ*XLEN-1:0]    req_wdata,
  input  logic [NREQ*XLEN-1:0]    req_wdata_hi,
  output logic [3:0]              crd_wen,
  output logic [CPRS_AW-1:0]      crd_addr,
  output logic [XLEN-1:0]         crd_wdata,
  output logic                    busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic                state;
  logic                next_state;
  logic [PW-1:0]       rr_ptr;
  logic [PW-1:0]       gidx;
  logic [NREQ-1:0]     grant;
  logic                any_valid;
  logic                take;

  logic                sel_pair;
  logic [CPRS_AW-1:0]  sel_addr;
  logic [3:0]          sel_wen;
  logic [XLEN-1:0]     sel_lo;
  logic [XLEN-1:0]     sel_hi;

  logic [CPRS_AW-1:0]  hi_addr;
  logic [3:0]          hi_wen;
  logic [XLEN-1:0]     hi_data;

  scarv_cop_rr_arb #(
    .N (NREQ)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .gidx  (gidx)
  );

  assign any_valid = |req_valid;

  // No grant while reset is asserted, so nothing is lost to a reset edge.
  assign take = (state == S_IDLE) && any_valid && !g_reset;

  always_comb begin
    sel_pair = 1'b0;
    sel_addr = '0;
    sel_wen  = '0;
    sel_lo   = '0;
    sel_hi   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_pair = sel_pair | req_pair[i];
        sel_addr = sel_addr | req_addr[i*CPRS_AW +: CPRS_AW];
        sel_wen  = sel_wen  | req_wen[i*4 +: 4];
        sel_lo   = sel_lo   | req_wdata[i*XLEN +: XLEN];
        sel_hi   = sel_hi   | req_wdata_hi[i*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (take && sel_pair) next_state = S_HI;
      S_HI:    next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = take ? grant : '0;
    busy      = (state == S_HI);
    g_clk_req = any_valid || (state != S_IDLE) || (|crd_wen);
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      rr_ptr    <= PW'(NREQ - 1);
      crd_wen   <= '0;
      crd_addr  <= '0;
      crd_wdata <= '0;
      hi_addr   <= '0;
      hi_wen    <= '0;
      hi_data   <= '0;
    end else if (state == S_HI) begin
      crd_wen   <= hi_wen;
      crd_addr  <= hi_addr;
      crd_wdata <= hi_data;
    end else if (take) begin
      rr_ptr    <= gidx;
      crd_wen   <= sel_wen;
      crd_addr  <= sel_addr;
      crd_wdata <= sel_lo;
      if (sel_pair) begin
        hi_addr <= sel_addr + 4'd1;
        hi_wen  <= sel_wen;
        hi_data <= sel_hi;
      end
    end else begin
      crd_wen <= '0;
    end
  end

endmodule

// File: tb/tb_scarv_cop_cprs_wrarb.sv
// Directed and randomized checks of the write-port arbiter against
// a queue-based model of expected register file writes.
module tb_scarv_cop_cprs_wrarb;

  localparam int N = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            g_clk_req;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_pair;
  logic [N*4-1:0]  req_addr;
  logic [N*4-1:0]  req_wen;
  logic [N*32-1:0] req_wdata;
  logic [N*32-1:0] req_wdata_hi;
  logic [3:0]      crd_wen;
  logic [3:0]      crd_addr;
  logic [31:0]     crd_wdata;
  logic            busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [3:0]  wen;
    logic [31:0] data;
  } wr_t;

  wr_t         q[$];
  wr_t         e;
  logic        hv[N];
  logic        hp[N];
  logic [3:0]  ha[N];
  logic [3:0]  hw[N];
  logic [31:0] hl[N];
  logic [31:0] hh[N];
  int          mptr;
  int          g;
  logic [3:0]  last_wen;
  logic        any_hv;

  always #5 clk = ~clk;

  scarv_cop_cprs_wrarb #(.NREQ(N)) dut (
    .g_clk        (clk),
    .g_reset      (rst),
    .g_clk_req    (g_clk_req),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_pair     (req_pair),
    .req_addr     (req_addr),
    .req_wen      (req_wen),
    .req_wdata    (req_wdata),
    .req_wdata_hi (req_wdata_hi),
    .crd_wen      (crd_wen),
    .crd_addr     (crd_addr),
    .crd_wdata    (crd_wdata),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic p,
                         input logic [3:0] a, input logic [3:0] w,
                         input logic [31:0] lo, input logic [31:0] hi);
    req_valid[i]            = v;
    req_pair[i]             = p;
    req_addr[i*4 +: 4]      = a;
    req_wen[i*4 +: 4]       = w;
    req_wdata[i*32 +: 32]   = lo;
    req_wdata_hi[i*32 +: 32] = hi;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) set_req(i, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    clear_all();
    set_req(0, 1, 0, 4'd1, 4'hF, 32'hA1, 0);
    set_req(1, 1, 0, 4'd2, 4'hF, 32'hB2, 0);
    set_req(2, 1, 0, 4'd3, 4'hF, 32'hC3, 0);
    tick();
    tick();
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_wen", 32'(crd_wen), 0);
    chk("rst_addr", 32'(crd_addr), 0);
    chk("rst_data", crd_wdata, 0);

    // Continuous singles: grants rotate 0,1,2,0.
    rst = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rr_ready", 32'(req_ready), 32'(1 << (k % 3)));
      tick();
      chk("rr_addr", 32'(crd_addr), 32'((k % 3) + 1));
      chk("rr_data", crd_wdata, (k % 3 == 0) ? 32'hA1 :
                                (k % 3 == 1) ? 32'hB2 : 32'hC3);
    end
    clear_all();
    tick();
    chk("idle_wen", 32'(crd_wen), 0);

    // Pair to register 15 wraps the high word to register 0.
    set_req(1, 1, 1, 4'hF, 4'hF, 32'h11111111, 32'h22222222);
    #1;
    chk("pair_ready", 32'(req_ready), 32'b010);
    tick();
    set_req(1, 0, 0, 0, 0, 0, 0);
    set_req(0, 1, 0, 4'd7, 4'h3, 32'h77, 0);
    #1;
    chk("pair_lo_addr", 32'(crd_addr), 32'hF);
    chk("pair_lo_data", crd_wdata, 32'h11111111);
    chk("pair_busy", 32'(busy), 1);
    chk("pair_hi_ready", 32'(req_ready), 0);
    tick();
    chk("pair_hi_addr", 32'(crd_addr), 0);
    chk("pair_hi_data", crd_wdata, 32'h22222222);
    chk("pair_hi_wen", 32'(crd_wen), 32'hF);
    chk("pair_done_busy", 32'(busy), 0);
    chk("after_pair_ready", 32'(req_ready), 32'b001);
    tick();
    set_req(0, 0, 0, 0, 0, 0, 0);
    chk("after_pair_addr", 32'(crd_addr), 7);
    chk("after_pair_wen", 32'(crd_wen), 3);

    // Partial and zero byte enables.
    set_req(2, 1, 0, 4'd5, 4'b0101, 32'h55, 0);
    #1;
    chk("wen5_ready", 32'(req_ready), 32'b100);
    tick();
    set_req(2, 1, 0, 4'd6, 4'b0000, 32'h66, 0);
    chk("wen5_wen", 32'(crd_wen), 32'b0101);
    chk("wen5_addr", 32'(crd_addr), 5);
    #1;
    chk("wen0_ready", 32'(req_ready), 32'b100);
    tick();
    set_req(2, 0, 0, 0, 0, 0, 0);
    chk("wen0_wen", 32'(crd_wen), 0);
    chk("wen0_addr", 32'(crd_addr), 6);
    chk("wen0_busy", 32'(busy), 0);

    // Reset during the high-word cycle abandons it.
    set_req(0, 1, 1, 4'd9, 4'hF, 32'hAA, 32'hBB);
    #1;
    chk("prst_ready", 32'(req_ready), 32'b001);
    tick();
    set_req(0, 0, 0, 0, 0, 0, 0);
    chk("prst_busy", 32'(busy), 1);
    chk("prst_addr", 32'(crd_addr), 9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("prst_wen", 32'(crd_wen), 0);
    chk("prst_idle", 32'(busy), 0);
    chk("prst_addr0", 32'(crd_addr), 0);
    tick();
    chk("prst_nohi", 32'(crd_wen), 0);
    set_req(0, 1, 0, 4'd1, 4'hF, 32'hA1, 0);
    set_req(1, 1, 0, 4'd2, 4'hF, 32'hB2, 0);
    set_req(2, 1, 0, 4'd3, 4'hF, 32'hC3, 0);
    #1;
    chk("prst_ptr", 32'(req_ready), 32'b001);
    clear_all();
    tick();
    tick();

    // Clock request follows request valid combinationally.
    chk("idle_clkreq", 32'(g_clk_req), 0);
    chk("idle_wen2", 32'(crd_wen), 0);
    req_valid[0] = 1'b1;
    #1;
    chk("wake_clkreq", 32'(g_clk_req), 1);
    req_valid[0] = 1'b0;
    tick();

    // Randomized traffic against a queue of expected writes.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mptr = N - 1;
    last_wen = 0;
    q.delete();
    for (int i = 0; i < N; i++) hv[i] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("rnd_wen", 32'(crd_wen), 32'(e.wen));
        chk("rnd_addr", 32'(crd_addr), 32'(e.addr));
        chk("rnd_data", crd_wdata, e.data);
        last_wen = e.wen;
      end else begin
        chk("rnd_idle_wen", 32'(crd_wen), 0);
        last_wen = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (!hv[i] && $urandom_range(2) == 0) begin
          hv[i] = 1'b1;
          hp[i] = 1'($urandom_range(1));
          ha[i] = 4'($urandom_range(15));
          hw[i] = ($urandom_range(4) == 0) ? 4'h0 : 4'($urandom_range(15));
          hl[i] = $urandom;
          hh[i] = $urandom;
          set_req(i, 1, hp[i], ha[i], hw[i], hl[i], hh[i]);
        end
      end
      #1;
      g = -1;
      any_hv = 1'b0;
      for (int i = 0; i < N; i++) any_hv = any_hv | hv[i];
      if (q.size() == 0) begin
        for (int d = 1; d <= N; d++) begin
          if (g < 0 && hv[(mptr + d) % N]) g = (mptr + d) % N;
        end
      end
      chk("rnd_ready", 32'(req_ready), (g >= 0) ? 32'(1 << g) : 0);
      chk("rnd_busy", 32'(busy), 32'(q.size() != 0));
      chk("rnd_clkreq", 32'(g_clk_req),
          32'(any_hv || q.size() != 0 || last_wen != 0));
      if (g >= 0) begin
        q.push_back('{addr: ha[g], wen: hw[g], data: hl[g]});
        if (hp[g]) q.push_back('{addr: ha[g] + 4'd1, wen: hw[g], data: hh[g]});
        mptr = g;
      end
      tick();
      if (g >= 0) begin
        hv[g] = 1'b0;
        set_req(g, 0, 0, 0, 0, 0, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
